// File: rtl/imm_pack_pkg.sv
// Shared constants for the immediate packer: class codes, header bytes and FSM states.
package imm_pack_pkg;

    localparam logic [1:0] CLS_S5  = 2'd0;
    localparam logic [1:0] CLS_S8  = 2'd1;
    localparam logic [1:0] CLS_S16 = 2'd2;

    localparam logic [7:0] HDR_S8  = 8'h20;
    localparam logic [7:0] HDR_S16 = 8'h40;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HDR   = 2'd1,
        ST_HI    = 2'd2,
        ST_LO    = 2'd3
    } state_t;

endpackage

// File: rtl/imm_classify.sv
// Picks the shortest signed class (S5 / S8 / S16) that represents a 16-bit value exactly.
module imm_classify
    import imm_pack_pkg::*;
(
    input  logic [15:0] in,
    output logic [1:0]  cls
);

    logic fits5;
    logic fits8;

    // A value fits N bits when every bit above N-1 matches the sign bit.
    assign fits5 = (&in[15:4]) | ~(|in[15:4]);
    assign fits8 = (&in[15:7]) | ~(|in[15:7]);

    always_comb begin
        if (fits5) begin
            cls = CLS_S5;
        end else if (fits8) begin
            cls = CLS_S8;
        end else begin
            cls = CLS_S16;
        end
    end

endmodule

// File: rtl/imm_pack.sv
// Packs 16-bit signed immediates into a 1/2/3-byte stream, one value in flight, zero-bubble between frames.
// Handshake: a transfer happens on a cycle where valid && ready; valid never drops until that transfer.
module imm_pack
    import imm_pack_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] cnt_s5,
    output logic [CNT_W-1:0] cnt_s8,
    output logic [CNT_W-1:0] cnt_s16
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] held;
    logic [1:0]  held_cls;
    logic [1:0]  in_cls;
    logic        accept;
    logic        fire;
    logic        last;

    imm_classify u_classify (
        .in  (in_data),
        .cls (in_cls)
    );

    assign fire   = out_valid && out_ready;
    assign last   = ((state == ST_HDR) && (held_cls == CLS_S5)) ||
                    ((state == ST_HI)  && (held_cls == CLS_S8)) ||
                    (state == ST_LO);
    assign in_ready = !rst && ((state == ST_EMPTY) || (fire && last));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (fire) begin
            if (last) begin
                state_nxt = ST_EMPTY;
            end else if (state == ST_HDR) begin
                state_nxt = ST_HI;
            end else if (state == ST_HI) begin
                state_nxt = ST_LO;
            end
        end
        // A new value may enter on the same edge that retires the previous frame.
        if (accept) begin
            state_nxt = ST_HDR;
        end
    end

    always_comb begin
        out_valid = (state != ST_EMPTY);
        out_data  = 8'h00;
        case (state)
            ST_HDR: begin
                if (held_cls == CLS_S5) begin
                    out_data = {3'b000, held[4:0]};
                end else if (held_cls == CLS_S8) begin
                    out_data = HDR_S8;
                end else begin
                    out_data = HDR_S16;
                end
            end
            ST_HI:   out_data = (held_cls == CLS_S16) ? held[15:8] : held[7:0];
            ST_LO:   out_data = held[7:0];
            default: out_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held     <= 16'h0000;
            held_cls <= CLS_S5;
            cnt_s5   <= '0;
            cnt_s8   <= '0;
            cnt_s16  <= '0;
        end else if (accept) begin
            held     <= in_data;
            held_cls <= in_cls;
            if (in_cls == CLS_S5 && cnt_s5 != '1) begin
                cnt_s5 <= cnt_s5 + CNT_W'(1);
            end
            if (in_cls == CLS_S8 && cnt_s8 != '1) begin
                cnt_s8 <= cnt_s8 + CNT_W'(1);
            end
            if (in_cls == CLS_S16 && cnt_s16 != '1) begin
                cnt_s16 <= cnt_s16 + CNT_W'(1);
            end
        end
    end

endmodule
